// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, FSM states and grant ids for the memory arbiter
package mem_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W = 4;
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
    typedef enum logic {GID_I, GID_D} gnt_id_t;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: counts stalled grant cycles and flags the one that reaches the limit
module mem_arb_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else if (clear) count <= '0;
        else if (enable) count <= count + W'(1);
    end
    // a zero limit never expires, so the wrapping count is harmless then
    assign expired = enable && limit != '0 && count + W'(1) == limit;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch and data requesters
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    state_t state, state_n;
    gnt_id_t last_gnt;
    logic pick_i, pick_d, in_gnt, expired, fin;
    // a port whose ack is out this cycle is still holding its finished request
    assign pick_i = i_req && !i_ack && (!(d_req && !d_ack) || last_gnt == GID_D);
    assign pick_d = d_req && !d_ack && !pick_i;
    assign in_gnt = state != IDLE;
    assign fin = in_gnt && (mem_ack || expired);
    mem_arb_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_gnt),
        .enable (in_gnt && !mem_ack),
        .limit  (TW'(TIMEOUT_CYCLES)),
        .expired(expired)
    );
    always_comb begin
        state_n = state;
        if (!in_gnt) state_n = pick_i ? GNT_I : pick_d ? GNT_D : IDLE;
        else if (fin) state_n = IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt  <= GID_D;
            i_ack     <= 1'b0;
            i_rdata   <= '0;
            i_err     <= 1'b0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            i_ack <= fin && state == GNT_I;
            d_ack <= fin && state == GNT_D;
            i_err <= fin && state == GNT_I && !mem_ack;
            d_err <= fin && state == GNT_D && !mem_ack;
            if (fin && state == GNT_I) i_rdata <= mem_ack ? mem_rdata : '0;
            if (fin && state == GNT_D) d_rdata <= mem_ack && !mem_we ? mem_rdata : '0;
            if (fin) mem_req <= 1'b0;
            if (!in_gnt && (pick_i || pick_d)) begin
                mem_req   <= 1'b1;
                last_gnt  <= pick_i ? GID_I : GID_D;
                mem_we    <= pick_d && d_we;
                mem_addr  <= pick_i ? i_addr : d_addr;
                mem_wdata <= pick_i ? '0 : d_wdata;
                mem_be    <= pick_i ? '1 : d_be;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a scripted memory responder
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_ack, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } res_t;

    txn_t        q_g[$];
    res_t        q_i[$];
    res_t        q_d[$];
    int          total = 0;
    int          bad = 0;
    int          ack_at = 1;
    int          gcnt = 0;
    int          req_cycles = 0;
    logic [31:0] rd_val = 32'h0;
    logic        stray = 1'b0;
    logic [31:0] mi = 32'h0;
    logic [31:0] md = 32'h0;
    logic        req_q = 1'b0;
    txn_t        cur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic go_i(input logic [31:0] a, input logic [31:0] er, input logic ee);
        q_g.push_back('{addr: a, we: 1'b0, wdata: 32'h0, be: 4'hF});
        q_i.push_back('{rdata: er, err: ee});
        i_addr = a;
        i_req = 1'b1;
    endtask

    task automatic go_d(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] er, input logic ee);
        q_g.push_back('{addr: a, we: w, wdata: wd, be: be});
        q_d.push_back('{rdata: er, err: ee});
        d_we = w;
        d_addr = a;
        d_wdata = wd;
        d_be = be;
        d_req = 1'b1;
    endtask

    // holds the request through the ack cycle and drops it just after
    task automatic wait_ack(input bit port, input int exp_lat, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? d_ack : i_ack) && n < 40);
        check(tag, n, exp_lat);
        @(posedge clk);
        #1;
        if (port) d_req = 1'b0;
        else i_req = 1'b0;
    endtask

    task automatic gap();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // memory model: acks on the ack_at-th cycle of a request, garbage data otherwise
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                gcnt++;
                mem_ack = (gcnt == ack_at);
                mem_rdata = mem_ack ? rd_val : 32'hBAD0BAD0;
            end else begin
                gcnt = 0;
                mem_ack = stray;
                mem_rdata = 32'h5A5A5A5A;
            end
        end
    end

    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mi = 32'h0;
                md = 32'h0;
                req_q = 1'b0;
            end else begin
                if (mem_req) req_cycles++;
                if (mem_req && !req_q) begin
                    if (q_g.size() == 0) check("unexp_grant", 1, 0);
                    else begin
                        cur = q_g.pop_front();
                        check("g_addr", mem_addr, cur.addr);
                        check("g_we", 32'(mem_we), 32'(cur.we));
                        check("g_be", 32'(mem_be), 32'(cur.be));
                        if (cur.we) check("g_wdata", mem_wdata, cur.wdata);
                    end
                end else if (mem_req) begin
                    check("hold_addr", mem_addr, cur.addr);
                    check("hold_we", 32'(mem_we), 32'(cur.we));
                    check("hold_be", 32'(mem_be), 32'(cur.be));
                    if (cur.we) check("hold_wdata", mem_wdata, cur.wdata);
                end
                req_q = mem_req;
                if (i_ack) begin
                    if (q_i.size() == 0) check("unexp_i_ack", 1, 0);
                    else begin
                        r = q_i.pop_front();
                        mi = r.rdata;
                        check("i_err", 32'(i_err), 32'(r.err));
                    end
                end
                if (d_ack) begin
                    if (q_d.size() == 0) check("unexp_d_ack", 1, 0);
                    else begin
                        r = q_d.pop_front();
                        md = r.rdata;
                        check("d_err", 32'(d_err), 32'(r.err));
                    end
                end
                check("i_rdata", i_rdata, mi);
                check("d_rdata", d_rdata, md);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        i_req = 1'b0;
        i_addr = 32'h0;
        d_req = 1'b0;
        d_we = 1'b0;
        d_addr = 32'h0;
        d_wdata = 32'h0;
        d_be = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_i_ack", 32'(i_ack), 0);
        check("rst_d_ack", 32'(d_ack), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", 32'(mem_be), 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        // first tie after reset goes to I, then D immediately after I's ack
        ack_at = 1;
        rd_val = 32'h11111111;
        go_i(32'h104, 32'h11111111, 1'b0);
        go_d(1'b0, 32'h204, 32'hAAAA5555, 4'hC, 32'h11111111, 1'b0);
        wait_ack(1'b0, 3, "tie1_i_lat");
        wait_ack(1'b1, 2, "tie1_d_lat");
        gap();
        ack_at = 2;
        rd_val = 32'hDEADBEEF;
        go_i(32'h100, 32'hDEADBEEF, 1'b0);
        wait_ack(1'b0, 4, "rd_i_lat");
        gap();
        // last grant was I, so this tie goes to D first
        ack_at = 1;
        rd_val = 32'h22222222;
        go_d(1'b0, 32'h208, 32'h0, 4'hF, 32'h22222222, 1'b0);
        go_i(32'h108, 32'h22222222, 1'b0);
        wait_ack(1'b1, 3, "tie2_d_lat");
        wait_ack(1'b0, 2, "tie2_i_lat");
        gap();
        rd_val = 32'h33333333;
        go_d(1'b1, 32'h200, 32'h12345678, 4'b0011, 32'h0, 1'b0);
        wait_ack(1'b1, 3, "wr_d_lat");
        gap();
        ack_at = 0;
        req_cycles = 0;
        go_d(1'b0, 32'h300, 32'h0, 4'hF, 32'h0, 1'b1);
        wait_ack(1'b1, 6, "tmo_lat");
        check("tmo_req_cycles", req_cycles, 4);
        gap();
        ack_at = 4;
        rd_val = 32'hCAFEF00D;
        req_cycles = 0;
        go_d(1'b0, 32'h304, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);
        wait_ack(1'b1, 6, "lim_lat");
        check("lim_req_cycles", req_cycles, 4);
        gap();
        stray = 1'b1;
        @(posedge clk);
        #1;
        stray = 1'b0;
        @(negedge clk);
        check("stray_i_ack", 32'(i_ack), 0);
        check("stray_d_ack", 32'(d_ack), 0);
        check("stray_mem_req", 32'(mem_req), 0);
        gap();
        // abort an in-flight data grant with reset; no ack may follow
        ack_at = 0;
        q_g.push_back('{addr: 32'h400, we: 1'b0, wdata: 32'h0, be: 4'hF});
        d_we = 1'b0;
        d_addr = 32'h400;
        d_be = 4'hF;
        d_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_pre_req", 32'(mem_req), 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_mem_req", 32'(mem_req), 0);
        check("abort_d_ack", 32'(d_ack), 0);
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        ack_at = 1;
        rd_val = 32'h77777777;
        go_i(32'h500, 32'h77777777, 1'b0);
        go_d(1'b0, 32'h504, 32'h0, 4'hF, 32'h77777777, 1'b0);
        wait_ack(1'b0, 3, "tie3_i_lat");
        wait_ack(1'b1, 2, "tie3_d_lat");
        gap();
        check("q_g_left", q_g.size(), 0);
        check("q_i_left", q_i.size(), 0);
        check("q_d_left", q_d.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
